fifo_stream_seq: RTL

- Sequencer for the bit-serial weight FIFO in the FP-INT MAC datapath.
- Accepts parallel INT weight words, serialises them LSB-first into the FIFO, then drains the FIFO as a framed bit stream to the bit-serial MAC.
- Owns the FIFO's wr_en/rd_en/din. Framing (first/last bit of each weight) follows a per-job runtime precision.

---
 rtl/fp_int_mac_pkg.sv | 17 +
 rtl/fifo_stream_seq_bit_serializer.sv | 65 ++++++
 rtl/fifo_stream_seq.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fp_int_mac_pkg.sv
// Shared types and default sizes for the FP-INT MAC weight path.
package fp_int_mac_pkg;

  localparam int DEF_MAX_PREC = 8;
  localparam int DEF_NW_W     = 8;
  localparam int DEF_PREC_W   = 4;

  // S_LOAD/S_DRAIN are used by the strict build, S_STREAM by the overlap build.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_DRAIN  = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/fifo_stream_seq_bit_serializer.sv
// Parallel-load shift register emitting prec_i bits LSB-first.
// A new word may load in the same cycle the previous word's last bit leaves.
module fifo_stream_seq_bit_serializer #(
  parameter int W  = 8,
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          allow_i,
  input  logic          in_valid_i,
  input  logic [W-1:0]  in_data_i,
  input  logic [PW-1:0] prec_i,
  input  logic          stall_i,
  output logic          in_ready_o,
  output logic          out_valid_o,
  output logic          out_bit_o,
  output logic          word_done_o
);

  logic [W-1:0]  shift_q, shift_d;
  logic [PW-1:0] idx_q, idx_d;
  logic          have_q, have_d;
  logic          fire;

  assign fire        = have_q & ~stall_i;
  assign word_done_o = fire & (idx_q == prec_i - PW'(1));
  assign in_ready_o  = allow_i & (~have_q | word_done_o);
  assign out_valid_o = have_q;
  assign out_bit_o   = shift_q[0];

  // Load beats shift: a load in the finishing cycle replaces the spent word.
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    have_d  = have_q;
    if (clr_i) begin
      shift_d = '0;
      idx_d   = '0;
      have_d  = 1'b0;
    end else if (in_valid_i && in_ready_o) begin
      shift_d = in_data_i;
      idx_d   = '0;
      have_d  = 1'b1;
    end else if (fire) begin
      shift_d = shift_q >> 1;
      idx_d   = idx_q + PW'(1);
      if (word_done_o) have_d = 1'b0;
    end
  end

  // Shift register state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_q <= '0;
      idx_q   <= '0;
      have_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      have_q  <= have_d;
    end
  end

endmodule

// File: rtl/fifo_stream_seq.sv
// Weight FIFO sequencer: serialises INT weight words into the bit FIFO,
// then drains it as a framed bit stream to the bit-serial MAC.
// FIFO_STREAM_OVERLAP_EN: merge LOAD and DRAIN into one STREAM state.
module fifo_stream_seq
  import fp_int_mac_pkg::*;
#(
  parameter int MAX_PREC = DEF_MAX_PREC,
  parameter int NW_W     = DEF_NW_W,
  parameter int PREC_W   = DEF_PREC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PREC_W-1:0] precision,
  input  logic [NW_W-1:0]   num_weights,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [MAX_PREC-1:0] w_data,
  output logic              fifo_wr_en,
  output logic              fifo_din,
  input  logic              fifo_full,
  output logic              fifo_rd_en,
  input  logic              fifo_dout,
  input  logic              fifo_empty,
  output logic              mac_valid,
  output logic              mac_bit,
  output logic              mac_first,
  output logic              mac_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = NW_W + PREC_W;

  state_t            state_q, state_d;
  logic [PREC_W-1:0] p_q, p_d, ph_q, ph_d;
  logic [NW_W-1:0]   n_q, n_d, wr_words_q, wr_words_d;
  logic [CNT_W-1:0]  total_q, total_d, rd_bits_q, rd_bits_d, ret_bits_q, ret_bits_d;
  logic              mac_vld_q, err_q, err_d;
  logic              legal, accept, write_st, read_st, allow, last_ret;
  logic              ser_have, ser_bit, word_done;

`ifdef FIFO_STREAM_OVERLAP_EN
  localparam state_t WR_ST = S_STREAM;
  localparam state_t RD_ST = S_STREAM;
`else
  localparam state_t WR_ST = S_LOAD;
  localparam state_t RD_ST = S_DRAIN;
`endif

  assign legal    = (precision != '0) && (precision <= PREC_W'(MAX_PREC)) && (num_weights != '0);
  assign accept   = (state_q == S_IDLE) && start && legal;
  assign write_st = (state_q == WR_ST);
  assign read_st  = (state_q == RD_ST);
  // While a word is still in flight it already counts against N.
  assign allow    = write_st && (ser_have ? (wr_words_q < n_q - NW_W'(1)) : (wr_words_q < n_q));
  assign last_ret = mac_vld_q && (ret_bits_q + CNT_W'(1) == total_q);

  fifo_stream_seq_bit_serializer #(.W(MAX_PREC), .PW(PREC_W)) u_ser (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (accept),
    .allow_i    (allow),
    .in_valid_i (w_valid),
    .in_data_i  (w_data),
    .prec_i     (p_q),
    .stall_i    (fifo_full),
    .in_ready_o (w_ready),
    .out_valid_o(ser_have),
    .out_bit_o  (ser_bit),
    .word_done_o(word_done)
  );

  assign fifo_wr_en = ser_have & ~fifo_full;
  assign fifo_din   = fifo_wr_en & ser_bit;
  assign fifo_rd_en = read_st && !fifo_empty && (rd_bits_q < total_q);
  assign mac_valid  = mac_vld_q;
  assign mac_bit    = mac_vld_q & fifo_dout;
  assign mac_first  = mac_vld_q && (ph_q == '0);
  assign mac_last   = mac_vld_q && (ph_q == p_q - PREC_W'(1));
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;

  // Next-state, counters and framing phase.
  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    n_d        = n_q;
    total_d    = total_q;
    wr_words_d = wr_words_q;
    rd_bits_d  = rd_bits_q;
    ret_bits_d = ret_bits_q;
    ph_d       = ph_q;
    err_d      = 1'b0;
    if (word_done)  wr_words_d = wr_words_q + NW_W'(1);
    if (fifo_rd_en) rd_bits_d  = rd_bits_q + CNT_W'(1);
    if (mac_vld_q) begin
      ret_bits_d = ret_bits_q + CNT_W'(1);
      ph_d       = (ph_q == p_q - PREC_W'(1)) ? '0 : ph_q + PREC_W'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (start && !legal) err_d = 1'b1;
        if (accept) begin
          p_d        = precision;
          n_d        = num_weights;
          total_d    = CNT_W'(num_weights) * CNT_W'(precision);
          wr_words_d = '0;
          rd_bits_d  = '0;
          ret_bits_d = '0;
          ph_d       = '0;
          state_d    = WR_ST;
        end
      end
`ifdef FIFO_STREAM_OVERLAP_EN
      S_STREAM: if (last_ret && (wr_words_d == n_q)) state_d = S_DONE;
`else
      S_LOAD:   if (wr_words_d == n_q) state_d = S_DRAIN;
      S_DRAIN:  if (last_ret) state_d = S_DONE;
`endif
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      p_q        <= '0;
      n_q        <= '0;
      total_q    <= '0;
      wr_words_q <= '0;
      rd_bits_q  <= '0;
      ret_bits_q <= '0;
      ph_q       <= '0;
      mac_vld_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      n_q        <= n_d;
      total_q    <= total_d;
      wr_words_q <= wr_words_d;
      rd_bits_q  <= rd_bits_d;
      ret_bits_q <= ret_bits_d;
      ph_q       <= ph_d;
      mac_vld_q  <= fifo_rd_en;
      err_q      <= err_d;
    end
  end

endmodule
